// File: rtl/nn_smoothgrad_polar_nchannel_pkg.sv
// Shared definitions for the multi-channel polar smooth-gradient accumulator:
// channel-index width helper and the per-channel step classification.
package nn_smoothgrad_polar_nchannel_pkg;

    typedef enum logic [1:0] {
        INC  = 2'd0,
        DEC  = 2'd1,
        FLIP = 2'd2,
        HOLD = 2'd3
    } stepType_t;

    // A single-channel build still needs a 1-bit index port.
    function automatic int chIdxWidth(input int nCh);
        return (nCh > 1) ? $clog2(nCh) : 1;
    endfunction

endpackage

// File: rtl/smoothgrad_polar_cell.sv
// One channel: sign/magnitude register, optional resistance counter and flip flag.
// Resistance counting is built only when SMOOTHGRAD_RESISTANCE_EN is defined.
module smoothgrad_polar_cell
    import nn_smoothgrad_polar_nchannel_pkg::*;
#(
    parameter int N            = 8,
    parameter int N_RESISTANCE = 9
) (
    input  logic                    CLK,
    input  logic                    INIT_N,
    input  logic                    EN,
    input  logic                    LOAD,
    input  logic                    sel,
    input  logic                    inSs,
    input  logic                    inSign,
    input  logic [N_RESISTANCE-1:0] resistance,
    input  logic [N-1:0]            outInit,
    input  logic                    signOutInit,
    output logic [N-1:0]            mag,
    output logic                    signOut,
    output logic                    flip
);

    localparam logic [N-1:0] MAG_MAX = '1;

    logic [N-1:0] magReg;
    logic [N-1:0] magNext;
    logic         signReg;
    logic         signNext;
    logic         flipReg;
    logic         applyStep;
    stepType_t    stepType;

`ifdef SMOOTHGRAD_RESISTANCE_EN
    logic [N_RESISTANCE-1:0] cntReg;
    logic [N_RESISTANCE-1:0] cntNext;
    logic [N_RESISTANCE:0]   cntInc;

    // Compare one bit wider so a counter left above a lowered threshold still fires.
    always_comb begin
        cntInc    = {1'b0, cntReg} + (N_RESISTANCE + 1)'(1);
        applyStep = 1'b0;
        cntNext   = cntReg;
        if (sel && inSs) begin
            if (cntInc >= {1'b0, resistance}) begin
                applyStep = 1'b1;
                cntNext   = '0;
            end else begin
                cntNext = cntInc[N_RESISTANCE-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!INIT_N || LOAD) begin
            cntReg <= '0;
        end else if (EN) begin
            cntReg <= cntNext;
        end
    end
`else
    logic unusedResistance;
    assign unusedResistance = ^resistance;
    assign applyStep        = sel && inSs;
`endif

    always_comb begin
        stepType = HOLD;
        if (applyStep) begin
            if (inSign == signReg) begin
                stepType = INC;
            end else if (magReg != '0) begin
                stepType = DEC;
            end else begin
                stepType = FLIP;
            end
        end
    end

    always_comb begin
        magNext  = magReg;
        signNext = signReg;
        case (stepType)
            INC: begin
                if (magReg != MAG_MAX) begin
                    magNext = magReg + N'(1);
                end
            end
            DEC:     magNext  = magReg - N'(1);
            FLIP:    signNext = inSign;
            default: begin
            end
        endcase
    end

    // The flip flag is a pulse: it is cleared on every edge that does not flip.
    always_ff @(posedge CLK) begin
        if (!INIT_N) begin
            magReg  <= '0;
            signReg <= 1'b0;
            flipReg <= 1'b0;
        end else if (LOAD) begin
            magReg  <= outInit;
            signReg <= signOutInit;
            flipReg <= 1'b0;
        end else if (EN) begin
            magReg  <= magNext;
            signReg <= signNext;
            flipReg <= (stepType == FLIP);
        end else begin
            flipReg <= 1'b0;
        end
    end

    assign mag     = magReg;
    assign signOut = signReg;
    assign flip    = flipReg;

endmodule

// File: rtl/nn_smoothgrad_polar_nchannel.sv
// Time-multiplexed N_CH-channel polar accumulator: a round-robin index selects the
// channel that samples its pulse each cycle. Optional feature: SMOOTHGRAD_RESISTANCE_EN.
module nn_smoothgrad_polar_nchannel
    import nn_smoothgrad_polar_nchannel_pkg::*;
#(
    parameter int N            = 8,
    parameter int N_CH         = 2,
    parameter int N_RESISTANCE = 9
) (
    input  logic                          CLK,
    input  logic                          INIT_N,
    input  logic                          EN,
    input  logic                          LOAD,
    input  logic [N_CH-1:0]               IN_SS,
    input  logic [N_CH-1:0]               SIGN,
    input  logic [N_RESISTANCE-1:0]       RESISTANCE,
    input  logic [N-1:0]                  OUT_INIT,
    input  logic                          SIGN_OUT_INIT,
    output logic [N_CH*N-1:0]             REG,
    output logic [N_CH-1:0]               SIGN_OUT,
    output logic [chIdxWidth(N_CH)-1:0]   CH_IDX,
    output logic                          TransitionChange_TRIG
);

    localparam int                 IDX_W    = chIdxWidth(N_CH);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_CH - 1);

    logic [IDX_W-1:0] chIdxReg;
    logic [IDX_W-1:0] chIdxNext;
    logic [N_CH-1:0]  flipVec;
    logic [N_CH-1:0]  signVec;

    always_comb begin
        chIdxNext = (chIdxReg == IDX_LAST) ? '0 : chIdxReg + IDX_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!INIT_N || LOAD) begin
            chIdxReg <= '0;
        end else if (EN) begin
            chIdxReg <= chIdxNext;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : gCell
            smoothgrad_polar_cell #(
                .N            (N),
                .N_RESISTANCE (N_RESISTANCE)
            ) uCell (
                .CLK         (CLK),
                .INIT_N      (INIT_N),
                .EN          (EN),
                .LOAD        (LOAD),
                .sel         (chIdxReg == IDX_W'(gi)),
                .inSs        (IN_SS[gi]),
                .inSign      (SIGN[gi]),
                .resistance  (RESISTANCE),
                .outInit     (OUT_INIT),
                .signOutInit (SIGN_OUT_INIT),
                .mag         (REG[gi*N +: N]),
                .signOut     (signVec[gi]),
                .flip        (flipVec[gi])
            );
        end
    endgenerate

    assign SIGN_OUT              = signVec;
    assign CH_IDX                = chIdxReg;
    assign TransitionChange_TRIG = |flipVec;

endmodule

// File: doc/nn_smoothgrad_polar_nchannel.md
NN_SMOOTHGRAD_POLAR_NCHANNEL -- requirements
Module: nn_smoothgrad_polar_nchannel

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning magnitude width per channel.
REQ-002 The block SHALL have parameter N_CH, default 2, meaning channel count (>=2).
REQ-003 The block SHALL have parameter N_RESISTANCE, default 9, meaning resistance counter width.
REQ-004 The block SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-005 The block SHALL have port INIT_N  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port EN  input  1  update enable; low freezes all state.
REQ-007 The block SHALL have port LOAD  input  1  synchronous preset of all channels.
REQ-008 The block SHALL have port IN_SS  input  N_CH  stochastic increment pulse per channel.
REQ-009 The block SHALL have port SIGN  input  N_CH  polarity of each IN_SS bit (1 = negative).
REQ-010 The block SHALL have port RESISTANCE  input  N_RESISTANCE  accepted pulses per applied step.
REQ-011 The block SHALL have port OUT_INIT  input  N  preset magnitude.
REQ-012 The block SHALL have port SIGN_OUT_INIT  input  1  preset sign.
REQ-013 The block SHALL have port REG  output  N_CH*N  flattened magnitudes; channel k at bits [k*N +: N].
REQ-014 The block SHALL have port SIGN_OUT  output  N_CH  per-channel sign.
REQ-015 The block SHALL have port CH_IDX  output  clog2(N_CH)  channel serviced this cycle.
REQ-016 The block SHALL have port TransitionChange_TRIG  output  1  one-cycle pulse on any sign flip.

Function
REQ-017 CH_IDX SHALL advance by 1 each cycle EN=1 and LOAD=0, wrapping N_CH-1 -> 0; it SHALL hold when EN=0.
REQ-018 Only channel CH_IDX SHALL sample IN_SS/SIGN in a cycle; other channels' pulses that cycle SHALL be ignored.
REQ-019 A sampled pulse (IN_SS[k]=1) SHALL increment that channel's resistance counter; the step SHALL be applied when counter+1 >= RESISTANCE, and the counter then cleared to 0; RESISTANCE=0 or 1 SHALL apply every pulse.
REQ-020 Applied step, sign match: magnitude +1, saturating at 2^N-1.
REQ-021 Applied step, sign mismatch, magnitude>0: magnitude -1, sign unchanged.
REQ-022 Applied step, sign mismatch, magnitude=0: magnitude stays 0, sign takes SIGN[k].
REQ-023 Register updates SHALL be visible on REG/SIGN_OUT one cycle after the sampling edge.
REQ-024 TransitionChange_TRIG SHALL be high for exactly the cycle after any SIGN_OUT bit changes via REQ-022; it SHALL NOT pulse on LOAD or reset.
REQ-025 LOAD=1 SHALL set every magnitude to OUT_INIT, every sign to SIGN_OUT_INIT, clear resistance counters and CH_IDX, regardless of EN.
REQ-026 Priority SHALL be INIT_N low > LOAD > EN low > update.
REQ-027 RESISTANCE changes mid-count SHALL take effect at the next comparison; a counter already >= new RESISTANCE SHALL apply on its next pulse.

Reset
REQ-028 At a rising edge with INIT_N=0: REG=0, SIGN_OUT=0, CH_IDX=0, counters=0, TransitionChange_TRIG=0.
REQ-029 Reset mid-count SHALL discard partial resistance counts; no step SHALL be applied that cycle.

Configuration
REQ-030 Macro SMOOTHGRAD_RESISTANCE_EN defined: REQ-019 and REQ-027 apply with per-channel counters.
REQ-031 Macro undefined: no counters are built, RESISTANCE is ignored, every sampled pulse is an applied step.

Structure
REQ-032 A shared package SHALL hold the channel-index width function and step-type encoding (INC, DEC, FLIP, HOLD).
REQ-033 One sub-module, smoothgrad_polar_cell, SHALL implement a single channel (magnitude, sign, resistance counter, flip flag), instantiated N_CH times; the top holds CH_IDX and the trigger OR.

Verification
REQ-034 N_CH=2, RESISTANCE=1, REG0=0 SIGN0=0, 10 pulses SIGN=0 on ch0 -> REG0=5 after 10 cycles (ch0 serviced every other cycle), REG1=0.
REQ-035 REG0=255 SIGN0=0, pulses SIGN=0 -> REG0 stays 255, no wrap.
REQ-036 REG0=1 SIGN0=0, two mismatching pulses -> REG0=0, then SIGN_OUT[0]=1, TransitionChange_TRIG high one cycle.
REQ-037 RESISTANCE=4 (macro on), 8 sampled pulses ch0 -> REG0 +2; macro off -> REG0 +8.
REQ-038 LOAD with OUT_INIT=100 SIGN_OUT_INIT=1 during EN=0 -> all REG=100, SIGN_OUT all 1, CH_IDX=0, no trigger.
REQ-039 INIT_N low while LOAD=1 and counters mid-count -> all outputs 0 next cycle; first pulse after release needs full RESISTANCE count.
